seg_display_scan: RTL

//  Output-side counterpart of the keypad matrix scanner: time-multiplexes a

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_display_scan_if.sv | 26 ++
 rtl/seg_hex_decoder.sv | 15 +
 rtl/seg_display_scan.sv | 122 ++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and hex glyph table for the multiplexed 7-segment display.
// Glyphs are active-low {g,f,e,d,c,b,a} for a common-anode part.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the glyph for hex digit n; the first element listed is F.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return GLYPH_TAB[nib];
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// CPU-side write port of the display scanner.
// The master writes digits; the slave reports an uncommitted update.
interface seg_display_scan_if #(
  parameter int DIGITS = 4
);

  logic                  data_we;
  logic [DIGITS*4-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  upd_pending;

  modport master (
    output data_we,
    output data_in,
    output dp_in,
    input  upd_pending
  );

  modport slave (
    input  data_we,
    input  data_in,
    input  dp_in,
    output upd_pending
  );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Thin wrapper so the table lives in one place.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg7 = seg_decode(nib);
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner, tear-free frame commit.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 5000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  seg_display_scan_if.slave bus,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IW-1:0] LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] TC_VAL = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK    = CW'(BLANK_CYC);

  logic [CW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic [DIGITS*4-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS*4-1:0] act_data;
  logic [DIGITS-1:0]   act_dp;
  logic                pending;

  logic                tc;
  logic                wrap;
  logic [3:0]          nib;
  logic                dp_bit;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   lz;

  assign tc     = (div_cnt == TC_VAL);
  assign wrap   = tc && (idx == LAST);
  assign nib    = act_data[{idx, 2'b00} +: 4];
  assign dp_bit = act_dp[idx];

  seg_hex_decoder u_dec (
    .nib  (nib),
    .seg7 (glyph)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every higher digit are "0" without dp.
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run   = run && (act_data[i*4 +: 4] == 4'h0) && !act_dp[i];
      lz[i] = run;
    end
  end
`else
  assign lz = '0;
`endif

  // Prescaler and digit index; index advances on terminal count.
  always_ff @(posedge clk) begin
    if (rstn) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tc) begin
      div_cnt <= '0;
      idx     <= (idx == LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Shadow capture and frame-boundary commit; a same-cycle write
  // lands in the shadow after the old shadow has been committed.
  always_ff @(posedge clk) begin
    if (rstn) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      act_data <= '0;
      act_dp   <= '0;
      pending  <= 1'b0;
    end else begin
      if (wrap && pending) begin
        act_data <= sh_data;
        act_dp   <= sh_dp;
      end
      if (bus.data_we) begin
        sh_data <= bus.data_in;
        sh_dp   <= bus.dp_in;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered pins: dead time at slot start, then one anode low.
  always_ff @(posedge clk) begin
    if (rstn) begin
      seg             <= SEG_OFF;
      an              <= '1;
      frame_done      <= 1'b0;
      bus.upd_pending <= 1'b0;
    end else begin
      frame_done      <= wrap;
      bus.upd_pending <= pending;
      if (div_cnt < BLK) begin
        seg <= SEG_OFF;
        an  <= '1;
      end else begin
        an  <= ~(DIGITS'(1) << idx);
        seg <= lz[idx] ? SEG_OFF : {~dp_bit, glyph};
      end
    end
  end

endmodule
